quad_rr_arbiter: RTL

- Sequential round-robin arbiter sharing one resource among four requesters (A..D → req[0..3]).
- Grant is one-hot active-low, in the same encoding as the team's 2-to-4 decoder outputs (1110, 1101, 1011, 0111; idle 1111), so gnt_n drives existing active-low selects directly.
- Adds a hold limit, a mandatory idle gap between owners, and status outputs.

---
 rtl/quad_rr_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/quad_rr_arbiter.sv
// Four-way round-robin arbiter with active-low one-hot grant, a per-ownership hold
// limit, and a forced two-cycle idle gap between successive owners.
//
// state     | meaning
// S_IDLE    | no owner; winner picked from req searching ptr+1 .. ptr
// S_GRANT   | owner ptr_q holds gnt_n low; hold counter advancing
// S_RELEASE | grant withdrawn for one cycle; req ignored
module quad_rr_arbiter #(
   parameter int MAX_HOLD = 8,
   parameter int CW       = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt_n,
   output logic [1:0] gnt_idx,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   if (MAX_HOLD < 1 || MAX_HOLD > 15 || (1 << CW) <= MAX_HOLD) begin : g_param_err
      $error("quad_rr_arbiter: MAX_HOLD must be 1..15 and fit in CW bits");
   end

   state_t        state_q;
   logic [3:0]    gnt_n_q;
   logic [1:0]    gnt_idx_q;
   logic          busy_q;
   logic          timeout_q;
   logic [1:0]    ptr_q;
   logic [CW-1:0] cnt_q;

   logic [1:0]    win_d;
   logic          found_d;
   logic [1:0]    cand_d;

   // Rotating priority: the last owner is searched last.
   always_comb begin
      win_d   = ptr_q;
      found_d = 1'b0;
      cand_d  = ptr_q;
      for (int k = 1; k <= 4; k++) begin
         cand_d = ptr_q + 2'(k);
         if (!found_d && req[cand_d]) begin
            win_d   = cand_d;
            found_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         gnt_n_q   <= 4'b1111;
         gnt_idx_q <= 2'd0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         ptr_q     <= 2'd3;
         cnt_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               timeout_q <= 1'b0;
               if (found_d) begin
                  state_q   <= S_GRANT;
                  gnt_n_q   <= ~(4'b0001 << win_d);
                  gnt_idx_q <= win_d;
                  busy_q    <= 1'b1;
                  cnt_q     <= '0;
                  ptr_q     <= win_d;
               end
            end
            S_GRANT: begin
               // A voluntary drop wins over the hold limit, so no timeout then.
               if (!req[ptr_q]) begin
                  state_q   <= S_RELEASE;
                  gnt_n_q   <= 4'b1111;
                  gnt_idx_q <= 2'd0;
                  busy_q    <= 1'b0;
                  timeout_q <= 1'b0;
                  cnt_q     <= '0;
               end else if (cnt_q == CW'(MAX_HOLD - 1)) begin
                  state_q   <= S_RELEASE;
                  gnt_n_q   <= 4'b1111;
                  gnt_idx_q <= 2'd0;
                  busy_q    <= 1'b0;
                  timeout_q <= 1'b1;
                  cnt_q     <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_RELEASE: begin
               state_q   <= S_IDLE;
               gnt_n_q   <= 4'b1111;
               gnt_idx_q <= 2'd0;
               busy_q    <= 1'b0;
               timeout_q <= 1'b0;
            end
            default: begin
               state_q   <= S_IDLE;
               gnt_n_q   <= 4'b1111;
               gnt_idx_q <= 2'd0;
               busy_q    <= 1'b0;
               timeout_q <= 1'b0;
               cnt_q     <= '0;
            end
         endcase
      end
   end

   assign gnt_n   = gnt_n_q;
   assign gnt_idx = gnt_idx_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;

endmodule
